// File: rtl/disp_scan_driver.sv
// disp_scan_driver
// Time-multiplexes an 8-digit hex word onto a common-anode 7-segment display.
// Each digit slot is a BLANK guard (all anodes off) followed by a SHOW period.
// The inputs are copied into shadow registers once per frame, so a mid-frame
// DISP_SEQ change never produces a torn frame.
//
// Ports:
//   CLK        system clock, rising edge
//   RST        asynchronous reset, active low
//   EN         scan enable; 0 holds the scan position and blanks the display
//   DISP_SEQ   eight hex digits, digit d = DISP_SEQ[4d+3:4d]
//   DISP_OFF   per-digit blank mask (1 = digit dark)
//   DP_I       per-digit decimal point (1 = lit)
//   AN         anodes, active low, AN[d] drives digit d
//   SEG        cathodes, active low, {g,f,e,d,c,b,a}
//   DP         decimal-point cathode, active low
//   FRAME_TICK one-clock pulse in the cycle after the shadow registers load
//
// state  | meaning
// BLANK  | guard interval, all anodes off, BLANK_CYCLES clocks
// SHOW   | digit idx lit (unless masked), CLK_DIV clocks
module disp_scan_driver #(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic [31:0] DISP_SEQ,
  input  logic [7:0]  DISP_OFF,
  input  logic [7:0]  DP_I,
  output logic [7:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP,
  output logic        FRAME_TICK
);

  localparam int MAXC = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] SHOW_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t          state_q;
  logic [2:0]      idx_q;
  logic [CW-1:0]   cnt_q;
  logic [31:0]     shadow_seq_q;
  logic [7:0]      shadow_off_q;
  logic [7:0]      shadow_dp_q;
  logic [7:0]      an_q;
  logic [6:0]      seg_q;
  logic            dp_q;
  logic            frame_tick_q;

  logic            load;
  logic            lit;
  logic [3:0]      cur_nib;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    // Frame boundary: start of the digit-0 guard slot.
    load    = EN && (state_q == ST_BLANK) && (idx_q == 3'd0) && (cnt_q == '0);
    lit     = EN && (state_q == ST_SHOW) && !shadow_off_q[idx_q];
    cur_nib = shadow_seq_q[{idx_q, 2'b00} +: 4];
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= ST_BLANK;
      idx_q        <= 3'd0;
      cnt_q        <= '0;
      shadow_seq_q <= 32'h0;
      shadow_off_q <= 8'hFF;
      shadow_dp_q  <= 8'h00;
      an_q         <= 8'hFF;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      frame_tick_q <= load;
      if (load) begin
        shadow_seq_q <= DISP_SEQ;
        shadow_off_q <= DISP_OFF;
        shadow_dp_q  <= DP_I;
      end

      // Outputs reflect the position held before this edge (one-clock lag).
      if (lit) begin
        an_q  <= ~(8'h01 << idx_q);
        seg_q <= seg_decode(cur_nib);
        dp_q  <= ~shadow_dp_q[idx_q];
      end else begin
        an_q  <= 8'hFF;
        seg_q <= 7'h7F;
        dp_q  <= 1'b1;
      end

      if (EN) begin
        case (state_q)
          ST_BLANK: begin
            if (cnt_q == BLANK_LAST) begin
              cnt_q   <= '0;
              state_q <= ST_SHOW;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: begin
            if (cnt_q == SHOW_LAST) begin
              cnt_q   <= '0;
              idx_q   <= idx_q + 3'd1;
              state_q <= ST_BLANK;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign AN         = an_q;
  assign SEG        = seg_q;
  assign DP         = dp_q;
  assign FRAME_TICK = frame_tick_q;

endmodule

// File: tb/tb_disp_scan_driver.sv
module tb_disp_scan_driver;

  localparam int CDIV  = 4;
  localparam int BLNK  = 1;
  localparam int P     = CDIV + BLNK;
  localparam int FRAME = 8 * P;

  logic        CLK, RST, EN;
  logic [31:0] DISP_SEQ;
  logic [7:0]  DISP_OFF, DP_I;
  logic [7:0]  AN;
  logic [6:0]  SEG;
  logic        DP, FRAME_TICK;

  int tests = 0;
  int fails = 0;

  disp_scan_driver #(.CLK_DIV(CDIV), .BLANK_CYCLES(BLNK)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .DISP_SEQ(DISP_SEQ), .DISP_OFF(DISP_OFF),
    .DP_I(DP_I), .AN(AN), .SEG(SEG), .DP(DP), .FRAME_TICK(FRAME_TICK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: position within the frame plus the frame-latched inputs.
  logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int          pos;
  logic [31:0] m_seq;
  logic [7:0]  m_off, m_dp;
  logic [7:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp, exp_ft;

  task automatic model_reset();
    pos = 0; m_seq = 32'h0; m_off = 8'hFF; m_dp = 8'h00;
    exp_an = 8'hFF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_ft = 1'b0;
  endtask

  // One clock: predict outputs for the coming edge, then advance.
  task automatic tick();
    int ph, d;
    ph = pos % P;
    d  = pos / P;
    if (EN && ph >= BLNK && !m_off[d]) begin
      exp_an  = ~(8'h01 << d);
      exp_seg = seg_tab[m_seq[4*d +: 4]];
      exp_dp  = ~m_dp[d];
    end else begin
      exp_an = 8'hFF; exp_seg = 7'h7F; exp_dp = 1'b1;
    end
    exp_ft = EN && (pos == 0);
    if (exp_ft) begin
      m_seq = DISP_SEQ; m_off = DISP_OFF; m_dp = DP_I;
    end
    if (EN) pos = (pos + 1) % FRAME;
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    #1;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b1;
  endtask

  task automatic test_reset();
    EN = 1'b1; DISP_SEQ = 32'h76543210; DISP_OFF = 8'h00; DP_I = 8'h01;
    RST = 1'b0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    tests++;
    if (AN !== 8'hFF || SEG !== 7'h7F || DP !== 1'b1 || FRAME_TICK !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold got an=%h seg=%h dp=%b ft=%b exp an=ff seg=7f dp=1 ft=0", AN, SEG, DP, FRAME_TICK);
    end
    RST = 1'b1;
    for (int i = 0; i < 13; i++) begin
      tick();
      tests++;
      if (AN !== exp_an || SEG !== exp_seg || DP !== exp_dp || FRAME_TICK !== exp_ft) begin
        fails++;
        $display("FAIL reset_run i=%0d got an=%h seg=%h dp=%b ft=%b exp an=%h seg=%h dp=%b ft=%b",
                 i, AN, SEG, DP, FRAME_TICK, exp_an, exp_seg, exp_dp, exp_ft);
      end
    end
    // Now mid-SHOW of digit 2; assert reset between edges.
    #3 RST = 1'b0;
    #1;
    tests++;
    if (AN !== 8'hFF || SEG !== 7'h7F || DP !== 1'b1 || FRAME_TICK !== 1'b0) begin
      fails++;
      $display("FAIL reset_async got an=%h seg=%h dp=%b ft=%b exp an=ff seg=7f dp=1 ft=0", AN, SEG, DP, FRAME_TICK);
    end
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b1;
    tick();
    tests++;
    if (FRAME_TICK !== 1'b1 || exp_ft !== 1'b1) begin
      fails++;
      $display("FAIL reset_first_tick got ft=%b exp 1", FRAME_TICK);
    end
    tick();
    tests++;
    if (FRAME_TICK !== 1'b0 || AN !== 8'hFE) begin
      fails++;
      $display("FAIL reset_second got ft=%b an=%h exp ft=0 an=fe", FRAME_TICK, AN);
    end
  endtask

  task automatic test_scan_order();
    int last_ft, n_ft;
    EN = 1'b1; DISP_SEQ = 32'h76543210; DISP_OFF = 8'h00; DP_I = 8'h01;
    do_reset();
    last_ft = -1; n_ft = 0;
    for (int i = 0; i < 2 * FRAME + 5; i++) begin
      tick();
      tests++;
      if (AN !== exp_an || SEG !== exp_seg || DP !== exp_dp || FRAME_TICK !== exp_ft) begin
        fails++;
        $display("FAIL scan i=%0d got an=%h seg=%h dp=%b ft=%b exp an=%h seg=%h dp=%b ft=%b",
                 i, AN, SEG, DP, FRAME_TICK, exp_an, exp_seg, exp_dp, exp_ft);
      end
      if (FRAME_TICK === 1'b1) begin
        if (last_ft >= 0) begin
          tests++;
          if (i - last_ft !== FRAME) begin
            fails++;
            $display("FAIL scan_frame_period got %0d exp %0d", i - last_ft, FRAME);
          end
        end
        last_ft = i; n_ft++;
      end
    end
    tests++;
    if (n_ft !== 3) begin
      fails++;
      $display("FAIL scan_tick_count got %0d exp 3", n_ft);
    end
  endtask

  task automatic test_blanking();
    EN = 1'b1; DISP_SEQ = 32'h76543210; DISP_OFF = 8'hF0; DP_I = 8'h01;
    do_reset();
    for (int i = 0; i < FRAME + 10; i++) begin
      tick();
      tests++;
      if (AN !== exp_an || SEG !== exp_seg || DP !== exp_dp || FRAME_TICK !== exp_ft) begin
        fails++;
        $display("FAIL blank i=%0d got an=%h seg=%h dp=%b ft=%b exp an=%h seg=%h dp=%b ft=%b",
                 i, AN, SEG, DP, FRAME_TICK, exp_an, exp_seg, exp_dp, exp_ft);
      end
    end
  endtask

  task automatic test_tear_free();
    bit changed, seen4;
    EN = 1'b1; DISP_SEQ = 32'h76543210; DISP_OFF = 8'h00; DP_I = 8'h00;
    do_reset();
    changed = 0; seen4 = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      tests++;
      if (AN !== exp_an || SEG !== exp_seg || DP !== exp_dp || FRAME_TICK !== exp_ft) begin
        fails++;
        $display("FAIL tear i=%0d got an=%h seg=%h dp=%b ft=%b exp an=%h seg=%h dp=%b ft=%b",
                 i, AN, SEG, DP, FRAME_TICK, exp_an, exp_seg, exp_dp, exp_ft);
      end
      if (changed && !seen4 && AN === 8'hEF) begin
        seen4 = 1;
        tests++;
        if (SEG !== 7'h19) begin
          fails++;
          $display("FAIL tear_digit4 got seg=%h exp 19", SEG);
        end
      end
      if (!changed && AN === 8'hF7) begin
        DISP_SEQ = 32'hFFFFFFFF;
        changed = 1;
      end
    end
    tests++;
    if (!seen4) begin
      fails++;
      $display("FAIL tear_no_digit4 got seen=0 exp 1");
    end
  endtask

  task automatic test_enable_freeze();
    int n_fb;
    bit done;
    EN = 1'b1; DISP_SEQ = $urandom; DISP_OFF = 8'h00; DP_I = 8'($urandom);
    do_reset();
    n_fb = 0; done = 0;
    for (int i = 0; i < 60; i++) begin
      EN = (pos == 12 && i < 30) ? 1'b0 : EN;
      if (!EN && i >= 1) begin
        // hold EN low for 10 clocks
      end
      tick();
      tests++;
      if (AN !== exp_an || SEG !== exp_seg || DP !== exp_dp || FRAME_TICK !== exp_ft) begin
        fails++;
        $display("FAIL freeze i=%0d got an=%h seg=%h dp=%b ft=%b exp an=%h seg=%h dp=%b ft=%b",
                 i, AN, SEG, DP, FRAME_TICK, exp_an, exp_seg, exp_dp, exp_ft);
      end
      if (!EN) begin
        for (int k = 0; k < 9; k++) begin
          tick();
          tests++;
          if (AN !== 8'hFF || SEG !== 7'h7F || DP !== 1'b1 || FRAME_TICK !== 1'b0) begin
            fails++;
            $display("FAIL freeze_blank k=%0d got an=%h seg=%h dp=%b ft=%b exp an=ff seg=7f dp=1 ft=0",
                     k, AN, SEG, DP, FRAME_TICK);
          end
        end
        EN = 1'b1;
        i = 30;
      end
      if (AN === 8'hFB && !done) n_fb++;
      if (AN === 8'hF7) done = 1;
    end
    tests++;
    if (n_fb !== CDIV) begin
      fails++;
      $display("FAIL freeze_digit2_len got %0d exp %0d", n_fb, CDIV);
    end
  endtask

  task automatic test_decode_sweep();
    EN = 1'b1; DISP_OFF = 8'h00; DP_I = 8'h00;
    DISP_SEQ = {$urandom} & 32'hFFFF_FFF0;
    do_reset();
    for (int v = 0; v < 16; v++) begin
      DISP_SEQ = ({$urandom} & 32'hFFFF_FFF0) | 32'(v);
      for (int i = 0; i < FRAME; i++) begin
        tick();
        tests++;
        if (AN !== exp_an || SEG !== exp_seg || DP !== exp_dp || FRAME_TICK !== exp_ft) begin
          fails++;
          $display("FAIL sweep v=%0d i=%0d got an=%h seg=%h dp=%b ft=%b exp an=%h seg=%h dp=%b ft=%b",
                   v, i, AN, SEG, DP, FRAME_TICK, exp_an, exp_seg, exp_dp, exp_ft);
        end
        if (i == 2) begin
          tests++;
          if (AN !== 8'hFE || SEG !== seg_tab[v]) begin
            fails++;
            $display("FAIL sweep_code v=%0d got an=%h seg=%h exp an=fe seg=%h", v, AN, SEG, seg_tab[v]);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    EN = 1'b1; DISP_SEQ = $urandom; DISP_OFF = 8'($urandom); DP_I = 8'($urandom);
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(9) == 0) DISP_SEQ = $urandom;
      if ($urandom_range(9) == 0) DISP_OFF = 8'($urandom);
      if ($urandom_range(9) == 0) DP_I = 8'($urandom);
      EN = ($urandom_range(5) != 0);
      tick();
      tests++;
      if (AN !== exp_an || SEG !== exp_seg || DP !== exp_dp || FRAME_TICK !== exp_ft) begin
        fails++;
        $display("FAIL random i=%0d got an=%h seg=%h dp=%b ft=%b exp an=%h seg=%h dp=%b ft=%b",
                 i, AN, SEG, DP, FRAME_TICK, exp_an, exp_seg, exp_dp, exp_ft);
      end
    end
  endtask

  initial begin
    RST = 1'b0; EN = 1'b0; DISP_SEQ = 32'h0; DISP_OFF = 8'h00; DP_I = 8'h00;
    model_reset();
    test_reset();
    test_scan_order();
    test_blanking();
    test_tear_free();
    test_enable_freeze();
    test_decode_sweep();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
